pool_1: RTL and testbench
=========================

// Module: pool_1
// PURPOSE
//  First LeNet max-pool stage, directly downstream of the first conv layer. Reads 20 conv1 maps (24x24, int8) from the conv1 result BRAM.
//  Applies 2x2 stride-2 signed max pooling and writes 20 maps (12x12) to the pool1 result BRAM.
//  Runs one full layer per enable session, then reports completion.
// PARAMETERS
//  CONV1_DEEP     20   number of feature maps (filters) processed
//  CONV1_OUTPUT   24   input map side (conv1 output side)
//  POOL1_OUTPUT   12   output map side (= CONV1_OUTPUT/2)
//  DATA_SIZE      8    element width, two's-complement
//  READ_WAIT      3    cycles from BRAM ena/addr to capture of douta
//  CONV_BASE      0    base address of conv1 results in source BRAM
//  POOL_BASE      0    base address of pool1 results in destination BRAM
// PORTS
//  clk                    in   1   clock, rising edge
//  rst                    in   1   asynchronous reset, active-low
//  pool_1_en              in   1   run enable; low pauses, low after finish re-arms
//  conv_result_bram_douta in   8   conv1 result BRAM read data
//  conv_result_bram_ena   out  1   conv1 result BRAM enable
//  conv_result_bram_addra out  15  conv1 result BRAM address
//  pool_result_bram_ena   out  1   pool1 result BRAM enable
//  pool_result_bram_wea   out  1   pool1 result BRAM write enable
//  pool_result_bram_addra out  13  pool1 result BRAM address
//  pool_result_bram_dina  out  8   pool1 result BRAM write data
//  pool_1_finish          out  1   layer complete, held until pool_1_en low
// BEHAVIOUR
//  Reset (rst=0, async): state=S_IDLE; all enables, addresses, dina and finish = 0; counters f,r,c,k = 0.
//  pool_1_en=0 outside S_DONE: state, counters and all outputs hold (pause). On resume, continue from that cycle.
//  S_IDLE (1 cyc): clear f,r,c,k,circle. Set max=0x80 (-128). -> S_CHECK.
//  S_CHECK (1 cyc): if f==CONV1_DEEP, assert finish and drop all enables -> S_DONE. Else set k=0, circle=0, max=0x80 -> S_LOAD.
//  S_LOAD: fetch window element k=0..3, with dy=k[1], dx=k[0].
//   circle 0: conv ena=1 and
//     addra = CONV_BASE + f*576 + (2r+dy)*24 + 2c+dx.
//   circle READ_WAIT: compare douta against max (signed); if douta is greater, max is updated. Then k++, circle=0.
//   Other circle values: circle++.
//   When k==4 (1 cyc): conv ena=0 -> S_COMPARE.
//  S_COMPARE (1 cyc): result<=max -> S_STORE.
//  S_STORE:
//   circle 0: ena=wea=1, addra=POOL_BASE+f*144+r*12+c, dina=result.
//   circle 3: ena=wea=0. Advance c. When c wraps 11->0, r++. When r wraps 11->0, f++. Then -> S_CHECK.
//  S_DONE: finish=1 while pool_1_en=1. When pool_1_en=0, finish=0 -> S_IDLE; a new rising pool_1_en reruns the layer.
//  Comparison is strict signed greater-than. On ties the earlier value is kept; the result is identical either way.
//  No arithmetic saturation is needed because the output is one of the inputs.
//  Timing (READ_WAIT=3, no pause): 23 cycles per output (CHECK 1 + LOAD 17 + COMPARE 1 + STORE 4).
//   finish rises 1+2880*23+1 = 66242 cycles after first enabled edge.
//  Address ranges: reads 0..11519, writes 0..2879 (bases 0). Address is computed in 32-bit and truncated to port width.
//  Each source element is read exactly once; each destination address is written exactly once per run.
// TESTING
//  T1 reset: rst=0 mid-S_LOAD -> all outputs 0 immediately (async). After rst=1 with en=1, the run restarts at f=r=c=0.
//  T2 window: map0 (0,0),(0,1),(1,0),(1,1) = 0xFB,0x03,0x80,0x02 -> write addr 0, dina=0x03.
//   Read order is 0,1,24,25.
//  T3 all-negative: window 0xFF,0xFE,0xFD,0x80 -> dina=0xFF (-1), not 0x80 and not unsigned 0xFF-by-luck.
//   Verify with a second window 0x81,0x80,0x80,0x80 -> dina=0x81.
//  T4 full layer: BRAM filled with a random int8 pattern -> 2880 writes match golden max-pool.
//   Last window reads are 11494, 11495, 11518, 11519; last write is addr 2879.
//   finish rises at cycle 66242 and stays high while en=1.
//  T5 pause: drop pool_1_en for 10 cycles during S_STORE circle 1 -> outputs frozen.
//   Final data is identical to T4 and finish is delayed by exactly 10 cycles.
//  T6 re-arm: after finish, en=0 for 1 cycle -> finish=0. en=1 again -> second run produces identical writes.

Source files
------------

// File: rtl/pool_1.sv
// LeNet pool1: 2x2 stride-2 signed max pooling over the conv1 result maps.
// Reads conv1 BRAM one window element at a time and writes one result per window.
module pool_1 #(
   parameter int CONV1_DEEP   = 20,
   parameter int CONV1_OUTPUT = 24,
   parameter int POOL1_OUTPUT = 12,
   parameter int DATA_SIZE    = 8,
   parameter int READ_WAIT    = 3,
   parameter int CONV_BASE    = 0,
   parameter int POOL_BASE    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pool_1_en,
   input  logic [DATA_SIZE-1:0] conv_result_bram_douta,
   output logic                 conv_result_bram_ena,
   output logic [14:0]          conv_result_bram_addra,
   output logic                 pool_result_bram_ena,
   output logic                 pool_result_bram_wea,
   output logic [12:0]          pool_result_bram_addra,
   output logic [DATA_SIZE-1:0] pool_result_bram_dina,
   output logic                 pool_1_finish
);

   localparam int FW  = $clog2(CONV1_DEEP + 1);
   localparam int PW  = $clog2(POOL1_OUTPUT);
   localparam int RWW = $clog2(READ_WAIT + 1);
   localparam int CW  = (RWW > 2) ? RWW : 2;

   localparam logic [FW-1:0] F_END  = FW'(CONV1_DEEP);
   localparam logic [PW-1:0] P_LAST = PW'(POOL1_OUTPUT - 1);
   localparam logic [CW-1:0] RD_CAP = CW'(READ_WAIT);
   localparam logic [CW-1:0] WR_END = CW'(3);

   localparam logic [31:0] IN_MAP  = CONV1_OUTPUT * CONV1_OUTPUT;
   localparam logic [31:0] IN_ROW  = CONV1_OUTPUT;
   localparam logic [31:0] OUT_MAP = POOL1_OUTPUT * POOL1_OUTPUT;
   localparam logic [31:0] OUT_ROW = POOL1_OUTPUT;
   localparam logic [31:0] C_BASE  = CONV_BASE;
   localparam logic [31:0] P_BASE  = POOL_BASE;
   localparam logic [DATA_SIZE-1:0] MIN_VAL = {1'b1, {(DATA_SIZE-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_LOAD,
      S_COMPARE,
      S_STORE,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [FW-1:0]        f_q, f_d;
   logic [PW-1:0]        r_q, r_d;
   logic [PW-1:0]        c_q, c_d;
   logic [2:0]           k_q, k_d;
   logic [CW-1:0]        circle_q, circle_d;
   logic [DATA_SIZE-1:0] max_q, max_d;
   logic [DATA_SIZE-1:0] result_q, result_d;
   logic                 c_ena_q, c_ena_d;
   logic [14:0]          c_addr_q, c_addr_d;
   logic                 p_ena_q, p_ena_d;
   logic                 p_wea_q, p_wea_d;
   logic [12:0]          p_addr_q, p_addr_d;
   logic [DATA_SIZE-1:0] p_din_q, p_din_d;
   logic                 fin_q, fin_d;

   logic [31:0] rd_addr, wr_addr;

   // dy = k[1], dx = k[0] within the current 2x2 window
   always_comb begin
      rd_addr = C_BASE + 32'(f_q) * IN_MAP
              + (32'({r_q, 1'b0}) + 32'(k_q[1])) * IN_ROW
              + 32'({c_q, 1'b0}) + 32'(k_q[0]);
      wr_addr = P_BASE + 32'(f_q) * OUT_MAP
              + 32'(r_q) * OUT_ROW + 32'(c_q);
   end

   always_comb begin
      state_d  = state_q;
      f_d      = f_q;
      r_d      = r_q;
      c_d      = c_q;
      k_d      = k_q;
      circle_d = circle_q;
      max_d    = max_q;
      result_d = result_q;
      c_ena_d  = c_ena_q;
      c_addr_d = c_addr_q;
      p_ena_d  = p_ena_q;
      p_wea_d  = p_wea_q;
      p_addr_d = p_addr_q;
      p_din_d  = p_din_q;
      fin_d    = fin_q;
      if (pool_1_en || state_q == S_DONE) begin
         case (state_q)
            S_IDLE: begin
               f_d      = '0;
               r_d      = '0;
               c_d      = '0;
               k_d      = '0;
               circle_d = '0;
               max_d    = MIN_VAL;
               state_d  = S_CHECK;
            end
            S_CHECK: begin
               if (f_q == F_END) begin
                  fin_d   = 1'b1;
                  c_ena_d = 1'b0;
                  p_ena_d = 1'b0;
                  p_wea_d = 1'b0;
                  state_d = S_DONE;
               end else begin
                  k_d      = '0;
                  circle_d = '0;
                  max_d    = MIN_VAL;
                  state_d  = S_LOAD;
               end
            end
            S_LOAD: begin
               if (k_q == 3'd4) begin
                  c_ena_d = 1'b0;
                  state_d = S_COMPARE;
               end else if (circle_q == '0) begin
                  c_ena_d  = 1'b1;
                  c_addr_d = rd_addr[14:0];
                  circle_d = circle_q + 1'b1;
               end else if (circle_q == RD_CAP) begin
                  if ($signed(conv_result_bram_douta) > $signed(max_q))
                     max_d = conv_result_bram_douta;
                  k_d      = k_q + 3'd1;
                  circle_d = '0;
               end else begin
                  circle_d = circle_q + 1'b1;
               end
            end
            S_COMPARE: begin
               result_d = max_q;
               circle_d = '0;
               state_d  = S_STORE;
            end
            S_STORE: begin
               if (circle_q == '0) begin
                  p_ena_d  = 1'b1;
                  p_wea_d  = 1'b1;
                  p_addr_d = wr_addr[12:0];
                  p_din_d  = result_q;
                  circle_d = circle_q + 1'b1;
               end else if (circle_q == WR_END) begin
                  p_ena_d  = 1'b0;
                  p_wea_d  = 1'b0;
                  circle_d = '0;
                  if (c_q == P_LAST) begin
                     c_d = '0;
                     if (r_q == P_LAST) begin
                        r_d = '0;
                        f_d = f_q + 1'b1;
                     end else begin
                        r_d = r_q + 1'b1;
                     end
                  end else begin
                     c_d = c_q + 1'b1;
                  end
                  state_d = S_CHECK;
               end else begin
                  circle_d = circle_q + 1'b1;
               end
            end
            S_DONE: begin
               if (pool_1_en) begin
                  fin_d = 1'b1;
               end else begin
                  fin_d   = 1'b0;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         f_q      <= '0;
         r_q      <= '0;
         c_q      <= '0;
         k_q      <= '0;
         circle_q <= '0;
         max_q    <= MIN_VAL;
         result_q <= '0;
         c_ena_q  <= 1'b0;
         c_addr_q <= '0;
         p_ena_q  <= 1'b0;
         p_wea_q  <= 1'b0;
         p_addr_q <= '0;
         p_din_q  <= '0;
         fin_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         f_q      <= f_d;
         r_q      <= r_d;
         c_q      <= c_d;
         k_q      <= k_d;
         circle_q <= circle_d;
         max_q    <= max_d;
         result_q <= result_d;
         c_ena_q  <= c_ena_d;
         c_addr_q <= c_addr_d;
         p_ena_q  <= p_ena_d;
         p_wea_q  <= p_wea_d;
         p_addr_q <= p_addr_d;
         p_din_q  <= p_din_d;
         fin_q    <= fin_d;
      end
   end

   assign conv_result_bram_ena   = c_ena_q;
   assign conv_result_bram_addra = c_addr_q;
   assign pool_result_bram_ena   = p_ena_q;
   assign pool_result_bram_wea   = p_wea_q;
   assign pool_result_bram_addra = p_addr_q;
   assign pool_result_bram_dina  = p_din_q;
   assign pool_1_finish          = fin_q;

endmodule

// File: tb/tb_pool_1.sv
// Directed bench for pool_1: window cases, async reset, full layer
// with a pause, finish timing and re-arm.
module tb_pool_1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic [7:0]  douta;
   logic        c_ena;
   logic [14:0] c_addr;
   logic        p_ena;
   logic        p_wea;
   logic [12:0] p_addr;
   logic [7:0]  p_din;
   logic        fin;

   always #5 clk = ~clk;

   pool_1 dut (
      .clk                    (clk),
      .rst                    (rst),
      .pool_1_en              (en),
      .conv_result_bram_douta (douta),
      .conv_result_bram_ena   (c_ena),
      .conv_result_bram_addra (c_addr),
      .pool_result_bram_ena   (p_ena),
      .pool_result_bram_wea   (p_wea),
      .pool_result_bram_addra (p_addr),
      .pool_result_bram_dina  (p_din),
      .pool_1_finish          (fin)
   );

   logic [7:0] mem [0:32767];

   always @(posedge clk)
      if (c_ena) douta <= mem[c_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rd_q[$];
   int wr_a[$];
   int wr_d[$];
   int wr_c[$];
   logic        pe = 1'b0;
   logic [14:0] pa = '0;
   logic        pw = 1'b0;

   // log each distinct read address and each write (rising wea)
   always @(negedge clk) begin
      if (c_ena && (!pe || c_addr != pa)) rd_q.push_back(int'(c_addr));
      if (p_wea && !pw) begin
         wr_a.push_back(int'(p_addr));
         wr_d.push_back(int'(p_din));
         wr_c.push_back(cyc);
      end
      pe <= c_ena;
      pa <= c_addr;
      pw <= p_wea;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic longint pack();
      return {24'd0, c_ena, c_addr, p_ena, p_wea, p_addr, p_din, fin};
   endfunction

   function automatic int gold(input int idx);
      int f, r, c, m, v, a;
      f = idx / 144;
      r = (idx % 144) / 12;
      c = idx % 12;
      m = -128;
      for (int k = 0; k < 4; k++) begin
         a = f * 576 + (2 * r + k / 2) * 24 + 2 * c + k % 2;
         v = int'($signed(mem[a]));
         if (v > m) m = v;
      end
      return m & 255;
   endfunction

   task automatic wait_wr(input int n, input int budget);
      int t;
      t = 0;
      while (wr_a.size() < n && t < budget) begin
         @(negedge clk); #1;
         t++;
      end
      chk("wr_wait", longint'(wr_a.size() >= n), 1);
   endtask

   int st, wb, rb, t, frz, derr, oerr, rerr, nr, nw;
   longint snap;
   int rcnt [0:32767];
   int exp_rd [4];
   int last_rd [4];

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
      mem[0]  = 8'hFB; mem[1]  = 8'h03; mem[24] = 8'h80; mem[25] = 8'h02;
      mem[2]  = 8'hFF; mem[3]  = 8'hFE; mem[26] = 8'hFD; mem[27] = 8'h80;
      mem[4]  = 8'h81; mem[5]  = 8'h80; mem[28] = 8'h80; mem[29] = 8'h80;
      exp_rd  = '{0, 1, 24, 25};
      last_rd = '{11494, 11495, 11518, 11519};

      repeat (3) @(negedge clk);
      #1;
      chk("reset_outs", pack(), 0);

      // windows at (0,0), (0,1), (0,2)
      rst = 1'b1; en = 1'b1; st = cyc;
      wait_wr(3, 200);
      if (rd_q.size() >= 4)
         for (int i = 0; i < 4; i++) chk("rd_order", rd_q[i], exp_rd[i]);
      if (wr_a.size() >= 3) begin
         chk("wr0_addr", wr_a[0], 0);
         chk("wr0_data", wr_d[0], 8'h03);
         chk("wr0_cycle", wr_c[0] - st, 21);
         chk("wr1_allneg", wr_d[1], 8'hFF);
         chk("wr2_allneg", wr_d[2], 8'h81);
         chk("wr2_addr", wr_a[2], 2);
      end

      // async reset in the middle of a load
      t = 0;
      while (!c_ena && t < 100) begin @(negedge clk); #1; t++; end
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_async", pack(), 0);
      @(negedge clk); #1;
      rst = 1'b1; st = cyc; wb = wr_a.size(); rb = rd_q.size();

      // pause for 10 cycles in store circle 1 of write 100
      t = 0;
      while (!(p_wea && wr_a.size() - wb >= 100) && t < 5000) begin
         @(negedge clk); #1; t++;
      end
      chk("pause_hit", p_wea, 1);
      en = 1'b0;
      snap = pack();
      frz = 0;
      repeat (10) begin
         @(negedge clk); #1;
         if (pack() != snap) frz++;
      end
      en = 1'b1;
      chk("pause_frozen", frz, 0);

      t = 0;
      while (!fin && t < 70000) begin @(negedge clk); #1; t++; end
      chk("fin_cycle", cyc - st, 66252);
      repeat (5) @(negedge clk);
      #1;
      chk("fin_hold", fin, 1);

      nw = wr_a.size() - wb;
      chk("wr_count", nw, 2880);
      derr = 0; oerr = 0;
      for (int i = wb; i < wr_a.size(); i++) begin
         if (wr_a[i] != i - wb) oerr++;
         if (wr_d[i] != gold(wr_a[i] % 2880)) derr++;
      end
      chk("wr_order", oerr, 0);
      chk("wr_data", derr, 0);
      if (nw > 0) chk("wr_last", wr_a[wr_a.size() - 1], 2879);

      nr = rd_q.size() - rb;
      chk("rd_count", nr, 11520);
      for (int i = 0; i < 32768; i++) rcnt[i] = 0;
      for (int i = rb; i < rd_q.size(); i++) rcnt[rd_q[i]]++;
      rerr = 0;
      for (int i = 0; i < 32768; i++)
         if (rcnt[i] != ((i < 11520) ? 1 : 0)) rerr++;
      chk("rd_once", rerr, 0);
      if (nr >= 4) begin
         chk("rd_restart", rd_q[rb], 0);
         for (int i = 0; i < 4; i++)
            chk("rd_last", rd_q[rd_q.size() - 4 + i], last_rd[i]);
      end

      // re-arm and rerun
      en = 1'b0;
      @(negedge clk); #1;
      chk("fin_drop", fin, 0);
      en = 1'b1; st = cyc; wb = wr_a.size();
      wait_wr(wb + 5, 300);
      if (wr_a.size() >= wb + 5) begin
         chk("rerun_cycle", wr_c[wb] - st, 21);
         for (int j = 0; j < 5; j++)
            chk("rerun_wr", longint'(wr_a[wb + j]) * 256 + wr_d[wb + j],
                longint'(j) * 256 + gold(j));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
